// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared state encoding and default operand widths for the sequential multiplier
package seq_mul_pkg;
  localparam int M_DEF = 8;
  localparam int N_DEF = 8;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
endpackage

// File: rtl/twos_abs.sv
// twos_abs: conditional two's-complement negate, used both for operand magnitudes and the final product sign
module twos_abs #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);
  assign y = neg ? ~x + W'(1) : x;
endmodule

// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: N-cycle shift-and-add multiplier on unsigned magnitudes, with the sign applied at the end
module seq_shift_add_multiplier
  import seq_mul_pkg::*;
#(
  parameter int M = M_DEF,
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           signed_mode,
  input  logic [M-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M+N-1:0] C
);
  localparam int W  = M + N;
  localparam int CW = $clog2(N);
  state_e        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d, mcand_q, mcand_d, c_q, c_d;
  logic [N-1:0]  mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sign_q, sign_d;
  logic [M-1:0]  a_mag;
  logic [N-1:0]  b_mag;
  logic [W-1:0]  sum, c_fix;
  logic          last;
  twos_abs #(.W(M)) u_abs_a (.x(A), .neg(signed_mode & A[M-1]), .y(a_mag));
  twos_abs #(.W(N)) u_abs_b (.x(B), .neg(signed_mode & B[N-1]), .y(b_mag));
  twos_abs #(.W(W)) u_neg_c (.x(sum), .neg(sign_q), .y(c_fix));
  // The multiplier shifts right so its LSB is always the bit under examination
  assign sum       = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last      = cnt_q == CW'(N - 1);
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign C         = c_q;
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    c_d      = c_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d  = CALC;
        acc_d    = '0;
        mcand_d  = W'(a_mag);
        mplier_d = b_mag;
        cnt_d    = '0;
        sign_d   = signed_mode & (A[M-1] ^ B[N-1]);
      end
      CALC: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          c_d     = c_fix;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      c_q      <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      c_q      <= c_d;
    end
  end
endmodule
